// File: rtl/p405s_ifbtracepost_pkg.sv
// Shared trace-posting types: entry layout, type codes and FSM states.
package p405s_ifbtracepost_pkg;

  localparam int unsigned ENTRY_W = 32;
  localparam int unsigned ADDR_W  = 30;

  localparam logic [1:0] TRC_T_BR   = 2'b01;
  localparam logic [1:0] TRC_T_EXC  = 2'b10;
  localparam logic [1:0] TRC_T_SYNC = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    STOPPED
  } trc_state_e;

  typedef struct packed {
    logic [1:0]        ttype;
    logic [ADDR_W-1:0] addr;
  } trc_entry_t;

  // Type 00 is not a trace event and is dropped at capture.
  function automatic logic is_legal_type(input logic [1:0] t);
    return t != 2'b00;
  endfunction

endpackage

// File: rtl/p405s_ifbtracepost_if.sv
// Completion / trace-unit signal bundle for the trace posting stage.
interface p405s_ifbtracepost_if;

  logic        ICU_traceEnable;
  logic        XXX_traceDisable;
  logic        DBG_stopReq;
  logic        JTG_stopReq;
  logic        CMP_valid;
  logic [1:0]  CMP_type;
  logic [29:0] CMP_addr;
  logic [1:0]  CMP_es;
  logic        TRC_fifoFull;
  logic        TRC_fifoOneEntryFree;
  logic        TRC_se;
  logic        IFB_postEntry;
  logic [29:0] IFB_traceData;
  logic [1:0]  IFB_traceType;
  logic [1:0]  IFB_traceESL2;
  logic        IFB_seIdleSt;
  logic        IFB_stopAck;
  logic        IFB_holdReq;

  modport master (
    output ICU_traceEnable, XXX_traceDisable, DBG_stopReq, JTG_stopReq,
           CMP_valid, CMP_type, CMP_addr, CMP_es,
           TRC_fifoFull, TRC_fifoOneEntryFree, TRC_se,
    input  IFB_postEntry, IFB_traceData, IFB_traceType, IFB_traceESL2,
           IFB_seIdleSt, IFB_stopAck, IFB_holdReq
  );

  modport slave (
    input  ICU_traceEnable, XXX_traceDisable, DBG_stopReq, JTG_stopReq,
           CMP_valid, CMP_type, CMP_addr, CMP_es,
           TRC_fifoFull, TRC_fifoOneEntryFree, TRC_se,
    output IFB_postEntry, IFB_traceData, IFB_traceType, IFB_traceESL2,
           IFB_seIdleSt, IFB_stopAck, IFB_holdReq
  );

endinterface

// File: rtl/p405s_ifbtracepost_queue.sv
// Two-entry trace entry FIFO with 1-bit wrapping pointers and synchronous clear.
module p405s_ifbtracepost_queue
  import p405s_ifbtracepost_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic               i_clear,
  input  logic [ENTRY_W-1:0] i_data,
  output logic [1:0]         o_count,
  output logic [ENTRY_W-1:0] o_head,
  output logic [ENTRY_W-1:0] o_next
);

  logic [ENTRY_W-1:0] r_mem [2];
  logic               r_wr;
  logic               r_rd;
  logic [1:0]         r_count;

  // Pointer and occupancy tracking; push+pop together leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= ~r_wr;
      if (i_pop)  r_rd <= ~r_rd;
      if (i_push && !i_pop)      r_count <= r_count + 2'd1;
      else if (!i_push && i_pop) r_count <= r_count - 2'd1;
    end
  end

  // Storage write; a push while full and popping reuses the slot being read out.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wr] <= i_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];
  assign o_next  = r_mem[~r_rd];

endmodule

// File: rtl/p405s_ifbtracepost.sv
// Trace-entry posting stage: captures completion/sync events, queues them and
// posts to the trace FIFO under full / one-free backpressure.
module p405s_ifbtracepost
  import p405s_ifbtracepost_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic                CB,
  input  logic                coreReset,
  p405s_ifbtracepost_if.slave bus
);

  localparam logic [1:0] FULL_CNT = 2'(QDEPTH);

  trc_state_e  r_state;
  trc_state_e  w_nextState;
  logic        r_sePend;
  logic        r_post;
  logic [29:0] r_data;
  logic [1:0]  r_type;
  logic [1:0]  r_esl2;
  logic [29:0] r_lastAddr;

  logic        w_trcOn;
  logic        w_stopReq;
  logic        w_active;
  logic        w_pop;
  logic        w_room;
  logic        w_cmpPush;
  logic        w_syncPush;
  logic        w_hasSync;
  logic [1:0]  w_count;
  trc_entry_t  w_head;
  trc_entry_t  w_next;
  trc_entry_t  w_pushEntry;

  p405s_ifbtracepost_queue u_queue (
    .clk     (CB),
    .rst     (coreReset),
    .i_push  (w_cmpPush | w_syncPush),
    .i_pop   (w_pop),
    .i_clear (~w_active),
    .i_data  (w_pushEntry),
    .o_count (w_count),
    .o_head  (w_head),
    .o_next  (w_next)
  );

  // Queue control: completion entry wins the single push port over a pending sync.
  always_comb begin
    w_trcOn     = bus.ICU_traceEnable & ~bus.XXX_traceDisable;
    w_stopReq   = bus.DBG_stopReq | bus.JTG_stopReq;
    w_active    = w_trcOn & (r_state != IDLE);
    w_pop       = w_active & (w_count != 2'd0) & ~bus.TRC_fifoFull &
                  ~(r_post & bus.TRC_fifoOneEntryFree);
    w_room      = (w_count != FULL_CNT) | w_pop;
    w_cmpPush   = w_active & bus.CMP_valid & is_legal_type(bus.CMP_type) & w_room;
    w_syncPush  = w_active & r_sePend & ~w_cmpPush & w_room;
    w_pushEntry = w_cmpPush ? trc_entry_t'{ttype: bus.CMP_type, addr: bus.CMP_addr}
                            : trc_entry_t'{ttype: TRC_T_SYNC, addr: r_lastAddr};
    w_hasSync   = ((w_count != 2'd0) && (w_head.ttype == TRC_T_SYNC)) ||
                  ((w_count == 2'd2) && (w_next.ttype == TRC_T_SYNC));
  end

  // Next-state logic; losing trace enable overrides every state.
  always_comb begin
    w_nextState = r_state;
    if (!w_trcOn) begin
      w_nextState = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    w_nextState = RUN;
        RUN:     if (w_stopReq) w_nextState = DRAIN;
        DRAIN:   if ((w_count == 2'd0) && !r_sePend && !r_post) w_nextState = STOPPED;
        STOPPED: if (!w_stopReq) w_nextState = RUN;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CB) begin
    if (coreReset) r_state <= IDLE;
    else           r_state <= w_nextState;
  end

  // Registered post strobe/payload, execution status, sync request and last address.
  always_ff @(posedge CB) begin
    if (coreReset) begin
      r_post     <= 1'b0;
      r_data     <= '0;
      r_type     <= '0;
      r_esl2     <= '0;
      r_sePend   <= 1'b0;
      r_lastAddr <= '0;
    end else begin
      r_post <= w_pop;
      if (w_pop) begin
        r_data <= w_head.addr;
        r_type <= w_head.ttype;
      end
      r_esl2   <= w_trcOn ? bus.CMP_es : 2'b00;
      r_sePend <= w_active & ((r_sePend & ~w_syncPush) | bus.TRC_se);
      if (w_cmpPush) r_lastAddr <= bus.CMP_addr;
    end
  end

  assign bus.IFB_postEntry = r_post;
  assign bus.IFB_traceData = r_data;
  assign bus.IFB_traceType = r_type;
  assign bus.IFB_traceESL2 = r_esl2;
  assign bus.IFB_seIdleSt  = ~r_sePend & ~w_hasSync;
  assign bus.IFB_stopAck   = (r_state == STOPPED);
  assign bus.IFB_holdReq   = (w_count == FULL_CNT) || (r_state == DRAIN) || (r_state == STOPPED);

endmodule

// File: tb/tb_p405s_ifbtracepost.sv
// Bench for the trace posting stage: directed scenarios with literal
// expectations plus randomized traffic checked against a queue-based model.
module tb_p405s_ifbtracepost;

  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_STOP = 3;

  logic CB = 1'b0;
  logic coreReset;
  int   n_checks = 0;
  int   n_errors = 0;

  p405s_ifbtracepost_if bus ();

  p405s_ifbtracepost #(.QDEPTH(2)) dut (
    .CB        (CB),
    .coreReset (coreReset),
    .bus       (bus.slave)
  );

  always #5 CB = ~CB;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not end, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_q[$];
  int          m_mode;
  bit          m_sePend, m_post, m_valid;
  logic [29:0] m_data, m_last;
  logic [1:0]  m_type, m_esl2;
  logic [31:0] e;
  bit          on, stp, act, cp, sp, old_se, old_post;
  int          sz0;

  function automatic bit exp_seIdle();
    if (m_sePend) return 1'b0;
    foreach (m_q[i]) if (m_q[i][31:30] == 2'b11) return 1'b0;
    return 1'b1;
  endfunction

  initial m_valid = 1'b0;

  always @(posedge CB) begin
    if (coreReset) begin
      m_q.delete();
      m_mode = M_IDLE; m_sePend = 0; m_post = 0;
      m_data = '0; m_type = '0; m_esl2 = '0; m_last = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      on  = bus.ICU_traceEnable && !bus.XXX_traceDisable;
      stp = bus.DBG_stopReq || bus.JTG_stopReq;
      act = on && (m_mode != M_IDLE);
      sz0 = m_q.size();
      old_se = m_sePend; old_post = m_post;
      m_post = 0; cp = 0; sp = 0;
      if (act && sz0 > 0 && !bus.TRC_fifoFull && !(old_post && bus.TRC_fifoOneEntryFree)) begin
        e = m_q.pop_front();
        m_post = 1; m_type = e[31:30]; m_data = e[29:0];
      end
      if (act && bus.CMP_valid && bus.CMP_type != 2'b00 && m_q.size() < 2) begin
        m_q.push_back({bus.CMP_type, bus.CMP_addr});
        m_last = bus.CMP_addr; cp = 1;
      end
      if (act && old_se && !cp && m_q.size() < 2) begin
        m_q.push_back({2'b11, m_last}); sp = 1;
      end
      m_sePend = act && ((old_se && !sp) || bus.TRC_se);
      if (!on) begin
        m_mode = M_IDLE; m_q.delete();
      end else begin
        case (m_mode)
          M_IDLE:  m_mode = M_RUN;
          M_RUN:   if (stp) m_mode = M_DRAIN;
          M_DRAIN: if (sz0 == 0 && !old_se && !old_post) m_mode = M_STOP;
          default: if (!stp) m_mode = M_RUN;
        endcase
      end
      m_esl2 = on ? bus.CMP_es : 2'b00;
    end
  end

  // ---------------- compare / monitor ----------------
  logic [31:0] log_q[$];
  int          log_cyc[$];
  int          cyc = 0;
  bit          hold_seen;

  always @(negedge CB) begin
    cyc++;
    if (bus.IFB_postEntry === 1'b1) begin
      log_q.push_back({bus.IFB_traceType, bus.IFB_traceData});
      log_cyc.push_back(cyc);
    end
    if (bus.IFB_holdReq === 1'b1) hold_seen = 1;
    if (m_valid) begin
      chk("postEntry", 32'(bus.IFB_postEntry), 32'(m_post));
      if (m_post) begin
        chk("traceData", 32'(bus.IFB_traceData), 32'(m_data));
        chk("traceType", 32'(bus.IFB_traceType), 32'(m_type));
      end
      chk("traceESL2", 32'(bus.IFB_traceESL2), 32'(m_esl2));
      chk("seIdleSt", 32'(bus.IFB_seIdleSt), 32'(exp_seIdle()));
      chk("stopAck", 32'(bus.IFB_stopAck), 32'(m_mode == M_STOP));
      chk("holdReq", 32'(bus.IFB_holdReq),
          32'((m_q.size() == 2) || m_mode == M_DRAIN || m_mode == M_STOP));
      if (!coreReset && bus.CMP_valid) chk("proto_noValidDuringHold", 32'(bus.IFB_holdReq), 32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge CB); #1;
  endtask

  task automatic settle();
    @(negedge CB); #1;
  endtask

  task automatic ev(input logic [1:0] t, input logic [29:0] a);
    bus.CMP_valid = 1'b1; bus.CMP_type = t; bus.CMP_addr = a;
  endtask

  task automatic quiet();
    bus.CMP_valid = 1'b0; bus.TRC_se = 1'b0;
  endtask

  task automatic clear_log();
    log_q.delete(); log_cyc.delete(); hold_seen = 0;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_post"},   32'(bus.IFB_postEntry), 32'd0);
    chk({tag, "_esl2"},   32'(bus.IFB_traceESL2), 32'd0);
    chk({tag, "_seIdle"}, 32'(bus.IFB_seIdleSt),  32'd1);
    chk({tag, "_ack"},    32'(bus.IFB_stopAck),   32'd0);
    chk({tag, "_hold"},   32'(bus.IFB_holdReq),   32'd0);
  endtask

  int stop_cnt;
  bit stop_sel;
  bit got;

  initial begin
    coreReset = 1'b1;
    bus.ICU_traceEnable = 0; bus.XXX_traceDisable = 0;
    bus.DBG_stopReq = 0; bus.JTG_stopReq = 0;
    bus.CMP_valid = 0; bus.CMP_type = 0; bus.CMP_addr = 0; bus.CMP_es = 0;
    bus.TRC_fifoFull = 0; bus.TRC_fifoOneEntryFree = 0; bus.TRC_se = 0;
    repeat (2) step();
    settle();
    reset_vals("reset");

    coreReset = 1'b0; bus.ICU_traceEnable = 1'b1;
    repeat (2) step();

    // Basic posting: branch then exception, FIFO empty.
    clear_log();
    ev(2'b01, 30'h0000100); step();
    ev(2'b10, 30'h0000040); step();
    quiet(); repeat (4) step(); settle();
    chk("basic_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("basic_first", log_q[0], {2'b01, 30'h0000100});
      chk("basic_second", log_q[1], {2'b10, 30'h0000040});
      chk("basic_consecutive", 32'(log_cyc[1] - log_cyc[0]), 32'd1);
    end
    chk("basic_noHold", 32'(hold_seen), 32'd0);

    // One-free backpressure with two entries queued.
    clear_log();
    bus.TRC_fifoFull = 1;
    ev(2'b01, 30'h0000111); step();
    ev(2'b10, 30'h0000222); step();
    quiet(); step(); settle();
    chk("onefree_holdAtTwo", 32'(bus.IFB_holdReq), 32'd1);
    bus.TRC_fifoFull = 0; bus.TRC_fifoOneEntryFree = 1;
    step(); settle();
    chk("onefree_firstPost", 32'(log_q.size()), 32'd1);
    step(); settle();
    chk("onefree_gap", 32'(bus.IFB_postEntry), 32'd0);
    chk("onefree_stillOne", 32'(log_q.size()), 32'd1);
    bus.TRC_fifoOneEntryFree = 0;
    repeat (3) step(); settle();
    chk("onefree_total", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) chk("onefree_second", log_q[1], {2'b10, 30'h0000222});

    // Sync request coinciding with a branch.
    clear_log();
    ev(2'b01, 30'h00ABCDE); bus.TRC_se = 1; step();
    quiet(); settle();
    chk("sync_seIdleLow", 32'(bus.IFB_seIdleSt), 32'd0);
    repeat (5) step(); settle();
    chk("sync_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("sync_branch", log_q[0], {2'b01, 30'h00ABCDE});
      chk("sync_entry", log_q[1], {2'b11, 30'h00ABCDE});
    end
    chk("sync_seIdleBack", 32'(bus.IFB_seIdleSt), 32'd1);

    // Stop drain with two entries queued.
    clear_log();
    bus.TRC_fifoFull = 1;
    ev(2'b01, 30'h0003000); step();
    ev(2'b10, 30'h0003004); step();
    quiet(); bus.JTG_stopReq = 1; bus.TRC_fifoFull = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(); settle();
      if (bus.IFB_stopAck === 1'b1) got = 1;
    end
    chk("stop_ackWithinBound", 32'(got), 32'd1);
    chk("stop_drained", 32'(log_q.size()), 32'd2);
    chk("stop_hold", 32'(bus.IFB_holdReq), 32'd1);
    bus.JTG_stopReq = 0;
    step(); settle();
    chk("stop_ackDrop", 32'(bus.IFB_stopAck), 32'd0);
    chk("stop_holdDrop", 32'(bus.IFB_holdReq), 32'd0);

    // Disable mid-stream with two entries queued.
    clear_log();
    bus.TRC_fifoFull = 1; bus.CMP_es = 2'b11;
    ev(2'b01, 30'h0004000); step();
    ev(2'b10, 30'h0004004); step();
    quiet(); bus.XXX_traceDisable = 1; bus.TRC_fifoFull = 0;
    repeat (3) step(); settle();
    chk("disable_noPost", 32'(log_q.size()), 32'd0);
    chk("disable_esl2", 32'(bus.IFB_traceESL2), 32'd0);
    chk("disable_emptyHold", 32'(bus.IFB_holdReq), 32'd0);
    bus.XXX_traceDisable = 0;
    repeat (4) step(); settle();
    chk("disable_discarded", 32'(log_q.size()), 32'd0);
    chk("reenable_esl2", 32'(bus.IFB_traceESL2), 32'd3);
    bus.CMP_es = 0;

    // Reset while a post strobe is high.
    ev(2'b01, 30'h0000500); step();
    quiet(); step(); settle();
    chk("rst_postBefore", 32'(bus.IFB_postEntry), 32'd1);
    coreReset = 1; step(); settle();
    reset_vals("rstmid");
    chk("rstmid_data", 32'(bus.IFB_traceData), 32'd0);
    chk("rstmid_type", 32'(bus.IFB_traceType), 32'd0);
    coreReset = 0; repeat (2) step();

    // Randomized traffic against the model.
    stop_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      coreReset = ($urandom_range(0, 499) == 0);
      bus.ICU_traceEnable  = ($urandom_range(0, 99) != 0);
      bus.XXX_traceDisable = ($urandom_range(0, 149) == 0);
      if (stop_cnt > 0) stop_cnt--;
      else if ($urandom_range(0, 119) == 0) begin
        stop_cnt = $urandom_range(3, 25); stop_sel = $urandom_range(0, 1) == 1;
      end
      bus.JTG_stopReq = (stop_cnt > 0) && stop_sel;
      bus.DBG_stopReq = (stop_cnt > 0) && !stop_sel;
      bus.TRC_fifoFull = ($urandom_range(0, 3) == 0);
      bus.TRC_fifoOneEntryFree = ($urandom_range(0, 2) == 0);
      bus.TRC_se = ($urandom_range(0, 15) == 0);
      bus.CMP_es = 2'($urandom());
      bus.CMP_type = 2'($urandom());
      bus.CMP_addr = 30'($urandom());
      bus.CMP_valid = (bus.IFB_holdReq == 1'b0) && ($urandom_range(0, 1) == 1);
      step();
    end
    coreReset = 0; quiet();
    repeat (3) step(); settle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
